// File: rtl/dcache_if.sv
// Bus bundle between the dcache controller and its CPU, memory and SRAM neighbours.
// The master modport is the controller's view. The slave modport is the environment's view.
interface dcache_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;

    logic         mem_ack_i;
    logic [255:0] mem_data_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;

    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        input  mem_ack_i, mem_data_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        output mem_ack_i, mem_data_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i
    );
endinterface

// File: rtl/dcache_controller.sv
// L1 data cache control FSM: word hits served directly from the 2-way SRAM.
// Misses write back a dirty victim, refill the line from memory, then replay the access as a hit.
//
// state        | meaning
// IDLE         | serve hits, detect miss
// MISS         | sample LRU victim, issue write-back or refill
// WRITEBACK    | dirty victim line going to memory
// READMISS     | refill request outstanding
// READMISSOK   | refilled line written to SRAM, replay next cycle
module dcache_controller (
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_READMISS,
        S_READMISSOK
    } state_t;

    state_t         state_q, state_d;
    logic           mem_enable_q, mem_enable_d;
    logic           mem_write_q, mem_write_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [255:0]   mem_data_q, mem_data_d;
    logic [255:0]   line_q, line_d;

    logic           req;
    logic           hit;
    logic           write_hit;
    logic [3:0]     idx;
    logic [2:0]     word_sel;
    logic [22:0]    cpu_tag;
    logic [31:0]    cpu_line_addr;
    logic [255:0]   merged;
    logic           unused_ok;

    assign req           = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign hit           = bus.sram_hit_i;
    assign idx           = bus.cpu_addr_i[8:5];
    assign word_sel      = bus.cpu_addr_i[4:2];
    assign cpu_tag       = bus.cpu_addr_i[31:9];
    assign cpu_line_addr = {cpu_tag, idx, 5'b0};
    assign unused_ok     = ^bus.cpu_addr_i[1:0];

    always_comb begin
        merged = bus.sram_data_i;
        merged[{word_sel, 5'd0} +: 32] = bus.cpu_data_i;
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        line_d       = line_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) state_d = S_MISS;
            end
            S_MISS: begin
                mem_enable_d = 1'b1;
                if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = {bus.sram_tag_i[22:0], idx, 5'b0};
                    mem_data_d  = bus.sram_data_i;
                    state_d     = S_WRITEBACK;
                end else begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = cpu_line_addr;
                    state_d     = S_READMISS;
                end
            end
            S_WRITEBACK: begin
                // Drop enable for one cycle so the refill is a distinct request.
                if (bus.mem_ack_i) begin
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = cpu_line_addr;
                    state_d      = S_READMISS;
                end
            end
            S_READMISS: begin
                if (!mem_enable_q) begin
                    mem_enable_d = 1'b1;
                end else if (bus.mem_ack_i) begin
                    mem_enable_d = 1'b0;
                    line_d       = bus.mem_data_i;
                    state_d      = S_READMISSOK;
                end
            end
            S_READMISSOK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            line_q       <= line_d;
        end
    end

    assign write_hit = (state_q == S_IDLE) && bus.cpu_MemWrite_i && hit;

    assign bus.cpu_data_o    = bus.sram_data_i[{word_sel, 5'd0} +: 32];
    assign bus.cpu_stall_o   = rst_i && ((state_q != S_IDLE) || (req && !hit));

    assign bus.mem_enable_o  = mem_enable_q;
    assign bus.mem_write_o   = mem_write_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_data_o    = mem_data_q;

    // Refill writes a clean line; a store hit marks the line dirty.
    assign bus.sram_addr_o   = idx;
    assign bus.sram_enable_o = rst_i && req;
    assign bus.sram_write_o  = rst_i && (write_hit || (state_q == S_READMISSOK));
    assign bus.sram_tag_o    = (state_q == S_READMISSOK) ? {2'b10, cpu_tag} : {2'b11, cpu_tag};
    assign bus.sram_data_o   = (state_q == S_READMISSOK) ? line_q : merged;
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: 2-way LRU SRAM and latency-programmable memory around the DUT.
// Checks every cycle against a flat CPU-visible memory image, plus directed literal expectations.
module tb_dcache_controller;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    dcache_if bus();

    dcache_controller dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference image of memory as the CPU must see it
    logic [31:0]  gold    [int unsigned];
    logic [255:0] backing [int unsigned];

    function automatic int unsigned word_key(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    function automatic int unsigned line_key(input logic [31:0] a);
        return {5'd0, a[31:5]};
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (gold.exists(word_key(a))) return gold[word_key(a)];
        return init_word(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  wa;
        l = '0;
        for (int k = 0; k < 8; k++) begin
            wa = {a[31:5], k[2:0], 2'b00};
            l[32*k +: 32] = gold_word(wa);
        end
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  wa;
        if (backing.exists(line_key(a))) return backing[line_key(a)];
        l = '0;
        for (int k = 0; k < 8; k++) begin
            wa = {a[31:5], k[2:0], 2'b00};
            l[32*k +: 32] = init_word(wa);
        end
        return l;
    endfunction

    // ---------------- 2-way SRAM with one LRU bit per set
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic         sram_ready = 1'b0;
    logic         hit0, hit1, s_wway;
    logic [3:0]   s_idx;

    always_comb begin
        s_idx = bus.sram_addr_o;
        hit0  = bus.sram_enable_o && s_tag[s_idx][0][24] && (s_tag[s_idx][0][22:0] == bus.sram_tag_o[22:0]);
        hit1  = bus.sram_enable_o && s_tag[s_idx][1][24] && (s_tag[s_idx][1][22:0] == bus.sram_tag_o[22:0]);
        bus.sram_hit_i = hit0 || hit1;
        s_wway = hit0 ? 1'b0 : (hit1 ? 1'b1 : s_lru[s_idx]);
        bus.sram_tag_i  = s_tag[s_idx][s_wway];
        bus.sram_data_i = s_data[s_idx][s_wway];
    end

    always @(posedge clk_i) begin
        if (!sram_ready) begin
            for (int s = 0; s < 16; s++) begin
                s_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_tag[s][w]  <= '0;
                    s_data[s][w] <= '0;
                end
            end
            sram_ready <= 1'b1;
        end else if (rst_i && bus.sram_enable_o) begin
            if (bus.sram_write_o) begin
                s_tag[s_idx][s_wway]  <= bus.sram_tag_o;
                s_data[s_idx][s_wway] <= bus.sram_data_o;
                s_lru[s_idx]          <= ~s_wway;
            end else if (hit0 || hit1) begin
                s_lru[s_idx] <= ~s_wway;
            end
        end
    end

    // ---------------- memory responder: ack mem_lat cycles after a request appears
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } req_t;
    req_t reqs[$];
    int   mem_lat = 3;

    initial begin : responder
        int cnt;
        bit busy;
        busy = 0;
        cnt  = 0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            bus.mem_ack_i = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_enable_o) begin
                        if (bus.mem_write_o) backing[line_key(bus.mem_addr_o)] = bus.mem_data_o;
                        else bus.mem_data_i = mem_line(bus.mem_addr_o);
                    end
                end
            end else if (rst_i && bus.mem_enable_o) begin
                busy = 1;
                cnt  = mem_lat;
                reqs.push_back('{wr: bus.mem_write_o, addr: bus.mem_addr_o, data: bus.mem_data_o});
            end
        end
    end

    // ---------------- per-cycle compare against the reference image
    initial begin : compare
        logic         p_valid, p_en, p_ack, p_wr;
        logic [31:0]  p_addr;
        logic [255:0] p_data;
        logic [255:0] exp_line;
        logic         req;
        p_valid = 1'b0;
        p_en = 1'b0; p_ack = 1'b0; p_wr = 1'b0; p_addr = '0; p_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                p_valid = 1'b0;
            end else begin
                req = bus.cpu_MemRead_i || bus.cpu_MemWrite_i;
                chk("sram_addr", 256'(bus.sram_addr_o), 256'(bus.cpu_addr_i[8:5]));
                chk("sram_enable", 256'(bus.sram_enable_o), 256'(req));
                if (req && !bus.cpu_stall_o) chk("hit_on_complete", 256'(bus.sram_hit_i), 256'(1));
                if (bus.cpu_MemWrite_i && !bus.cpu_stall_o) begin
                    exp_line = bus.sram_data_i;
                    exp_line[{bus.cpu_addr_i[4:2], 5'd0} +: 32] = bus.cpu_data_i;
                    chk("store_write", 256'(bus.sram_write_o), 256'(1));
                    chk("store_tag", 256'(bus.sram_tag_o), 256'({2'b11, bus.cpu_addr_i[31:9]}));
                    chk("store_line", bus.sram_data_o, exp_line);
                    gold[word_key(bus.cpu_addr_i)] = bus.cpu_data_i;
                end else if (!bus.cpu_stall_o) begin
                    chk("no_stray_write", 256'(bus.sram_write_o), 256'(0));
                    if (bus.cpu_MemRead_i)
                        chk("load_data", 256'(bus.cpu_data_o), 256'(gold_word(bus.cpu_addr_i)));
                end
                if (bus.sram_write_o && bus.cpu_stall_o) begin
                    chk("refill_line", bus.sram_data_o, mem_line(bus.cpu_addr_i));
                    chk("refill_tag", 256'(bus.sram_tag_o), 256'({2'b10, bus.cpu_addr_i[31:9]}));
                end
                if (bus.mem_enable_o) chk("line_aligned", 256'(bus.mem_addr_o[4:0]), 256'(0));
                if (bus.mem_enable_o && bus.mem_write_o)
                    chk("wb_data", bus.mem_data_o, gold_line(bus.mem_addr_o));
                if (p_valid && p_en) begin
                    if (!p_ack) begin
                        chk("hold_enable", 256'(bus.mem_enable_o), 256'(1));
                        chk("hold_write", 256'(bus.mem_write_o), 256'(p_wr));
                        chk("hold_addr", 256'(bus.mem_addr_o), 256'(p_addr));
                        chk("hold_data", bus.mem_data_o, p_data);
                    end else begin
                        chk("gap_after_ack", 256'(bus.mem_enable_o), 256'(0));
                    end
                end
                p_valid = 1'b1;
                p_en    = bus.mem_enable_o;
                p_ack   = bus.mem_ack_i;
                p_wr    = bus.mem_write_o;
                p_addr  = bus.mem_addr_o;
                p_data  = bus.mem_data_o;
            end
        end
    end

    // ---------------- stimulus
    logic [31:0]  last_data;
    logic [24:0]  last_tag;
    logic [255:0] last_sdata;
    logic         last_swr;

    task automatic do_access(input logic [31:0] a, input logic [31:0] d,
                             input logic rd, input logic wr, output int stalls);
        @(posedge clk_i);
        #1;
        bus.cpu_addr_i     = a;
        bus.cpu_data_i     = d;
        bus.cpu_MemRead_i  = rd;
        bus.cpu_MemWrite_i = wr;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (!bus.cpu_stall_o) break;
            stalls++;
        end
        if (stalls >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: addr %0h still stalled after 300 cycles", a);
        end
        last_data  = bus.cpu_data_o;
        last_tag   = bus.sram_tag_o;
        last_sdata = bus.sram_data_o;
        last_swr   = bus.sram_write_o;
        @(posedge clk_i);
        #1;
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
    endtask

    task automatic chk_req(input string name, input int i, input logic wr, input logic [31:0] addr);
        if (reqs.size() > i) begin
            chk({name, "_wr"}, 256'(reqs[i].wr), 256'(wr));
            chk({name, "_addr"}, 256'(reqs[i].addr), 256'(addr));
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0d requests expected more than %0d", name, reqs.size(), i);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  st;
        bit  found;
        bit  quiet;
        bit  ack_seen;
        bus.cpu_addr_i     = '0;
        bus.cpu_data_i     = '0;
        bus.cpu_MemRead_i  = 1'b1;
        bus.cpu_MemWrite_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", 256'(bus.cpu_stall_o), 256'(0));
        chk("rst_sram_en", 256'(bus.sram_enable_o), 256'(0));
        chk("rst_sram_wr", 256'(bus.sram_write_o), 256'(0));
        chk("rst_mem_en", 256'(bus.mem_enable_o), 256'(0));
        chk("rst_mem_wr", 256'(bus.mem_write_o), 256'(0));
        @(posedge clk_i);
        #1;
        bus.cpu_MemRead_i = 1'b0;
        rst_i = 1'b1;

        // cold read miss
        reqs.delete();
        mem_lat = 3;
        do_access(32'h000, 32'h0, 1'b1, 1'b0, st);
        chk("t1_stall_cycles", 256'(st), 256'(7));
        chk("t1_nreq", 256'(reqs.size()), 256'(1));
        chk_req("t1_req0", 0, 1'b0, 32'h000);
        chk("t1_data", 256'(last_data), 256'(32'h5A5A_0000));

        // store hit then load back
        do_access(32'h004, 32'hDEAD_BEEF, 1'b0, 1'b1, st);
        chk("t2_stall_cycles", 256'(st), 256'(0));
        chk("t2_write", 256'(last_swr), 256'(1));
        chk("t2_tag", 256'(last_tag), 256'({2'b11, 23'd0}));
        chk("t2_word1", 256'(last_sdata[63:32]), 256'(32'hDEAD_BEEF));
        do_access(32'h004, 32'h0, 1'b1, 1'b0, st);
        chk("t2_load_stall", 256'(st), 256'(0));
        chk("t2_load", 256'(last_data), 256'(32'hDEAD_BEEF));

        // second way dirty, then a third tag forces a write-back
        reqs.delete();
        do_access(32'h200, 32'h0BAD_F00D, 1'b0, 1'b1, st);
        chk("t3a_stall_cycles", 256'(st), 256'(7));
        chk_req("t3a_req0", 0, 1'b0, 32'h200);
        reqs.delete();
        do_access(32'h400, 32'h0, 1'b1, 1'b0, st);
        chk("t3_stall_cycles", 256'(st), 256'(12));
        chk("t3_nreq", 256'(reqs.size()), 256'(2));
        chk_req("t3_req0", 0, 1'b1, 32'h000);
        chk_req("t3_req1", 1, 1'b0, 32'h400);
        if (reqs.size() > 0) chk("t3_wb_word1", 256'(reqs[0].data[63:32]), 256'(32'hDEAD_BEEF));
        chk("t3_data", 256'(last_data), 256'(32'h5A5A_0400));

        // reset in the middle of a write-back
        reqs.delete();
        mem_lat = 10;
        @(posedge clk_i);
        #1;
        bus.cpu_addr_i    = 32'h600;
        bus.cpu_MemRead_i = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (bus.mem_enable_o && bus.mem_write_o) begin
                found = 1;
                break;
            end
        end
        chk("t5_wb_started", 256'(found), 256'(1));
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus.cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        chk("t5_rst_mem_en", 256'(bus.mem_enable_o), 256'(0));
        chk("t5_rst_stall", 256'(bus.cpu_stall_o), 256'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        quiet = 1;
        ack_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (bus.mem_ack_i) ack_seen = 1;
            if (bus.mem_enable_o || bus.cpu_stall_o) quiet = 0;
        end
        chk("t5_late_ack_seen", 256'(ack_seen), 256'(1));
        chk("t5_idle_after_rst", 256'(quiet), 256'(1));

        // slow memory: both requests held for 20 cycles each
        reqs.delete();
        mem_lat = 20;
        do_access(32'h600, 32'h0, 1'b1, 1'b0, st);
        chk("t4_stall_cycles", 256'(st), 256'(46));
        chk_req("t4_req0", 0, 1'b1, 32'h200);
        chk_req("t4_req1", 1, 1'b0, 32'h600);
        if (reqs.size() > 0) chk("t4_wb_word0", 256'(reqs[0].data[31:0]), 256'(32'h0BAD_F00D));
        chk("t4_data", 256'(last_data), 256'(32'h5A5A_0600));

        // read and write together on a hit behave as a store
        mem_lat = 3;
        do_access(32'h60C, 32'h1234_5678, 1'b1, 1'b1, st);
        chk("t6_stall_cycles", 256'(st), 256'(0));
        chk("t6_write", 256'(last_swr), 256'(1));
        chk("t6_word3", 256'(last_sdata[127:96]), 256'(32'h1234_5678));
        do_access(32'h60C, 32'h0, 1'b1, 1'b0, st);
        chk("t6_load", 256'(last_data), 256'(32'h1234_5678));
        do_access(32'h600, 32'h0, 1'b1, 1'b0, st);
        chk("t6_word0_kept", 256'(last_data), 256'(32'h5A5A_0600));

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
